dm_pipe: RTL



---
 rtl/dm_pkg.sv | 35 +++
 rtl/dm_lane_align.sv | 62 ++++++
 rtl/dm_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the dm_pipe data memory and its lane aligner.
//   - access size encodings carried on req_size
//   - control FSM state encoding
//   - byte/half lane mask constants used by the store merge
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // True when the access size cannot be served at this byte offset.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational lane handling for a 32-bit memory word.
//   word_i   : current contents of the addressed word
//   off_i    : byte offset within the word (addr[1:0])
//   size_i   : access size (byte/half/word)
//   signed_i : sign-extend byte/half loads
//   wdata_i  : right-aligned store data
//   rdata_o  : extracted and extended load value
//   merged_o : word after merging the store data into the selected lane
// Alignment is not checked here; the caller gates errors.
module dm_lane_align (
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);
  import dm_pkg::*;

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    shift     = 5'd0;
    mask      = 32'hFFFF_FFFF;
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    rdata_o   = word_i;

    case (off_i)
      2'd0:    byte_lane = word_i[7:0];
      2'd1:    byte_lane = word_i[15:8];
      2'd2:    byte_lane = word_i[23:16];
      default: byte_lane = word_i[31:24];
    endcase
    half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_BYTE: begin
        shift   = {off_i, 3'b000};
        mask    = MASK_BYTE << shift;
        rdata_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        shift   = {off_i[1], 4'b0000};
        mask    = MASK_HALF << shift;
        rdata_o = {{16{signed_i & half_lane[15]}}, half_lane};
      end
      default: begin
        shift   = 5'd0;
        mask    = 32'hFFFF_FFFF;
        rdata_o = word_i;
      end
    endcase

    merged_o = (word_i & ~mask) | ((wdata_i << shift) & mask);
  end

endmodule

// File: rtl/dm_pipe.sv
// dm_pipe: word-organised data memory behind valid/ready request and
// response channels, one request outstanding at a time.
//   clk, reset                    : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_we/size/signed/addr/wdata : access description
//   req_pc                        : instruction PC, forwarded to the trace port
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata/rsp_err             : load result (0 for stores/errors), error flag
//   trace_*                       : committed-store event (pc, word address,
//                                   merged word) for the simulation trace line;
//                                   held low when DISPLAY_EN is 0
// After reset the whole array is swept to zero, one word per cycle, before
// the first request is accepted. rsp_valid rises exactly LAT cycles after
// the accepting edge.
module dm_pipe #(
  parameter int DEPTH_WORDS = 8192,
  parameter int LAT         = 1,
  parameter int DISPLAY_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);
  import dm_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e         state_q, state_d;
  logic [AW-1:0]  clr_idx_q, clr_idx_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic [AW-1:0]  word_idx;
  logic [1:0]     off;
  logic           range_err;
  logic           acc_err;
  logic           accept;
  logic           store_commit;
  logic [31:0]    old_word;
  logic [31:0]    load_val;
  logic [31:0]    merged_word;

  assign word_idx  = req_addr[AW+1:2];
  assign off       = req_addr[1:0];
  // Any address bit above the array span makes the access out of range.
  assign range_err = (req_addr >> (AW + 2)) != 32'd0;
  assign acc_err   = range_err | size_misaligned(req_size, off);

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign accept       = req_ready & req_valid;
  assign store_commit = accept & req_we & ~acc_err;

  assign old_word = mem_q[word_idx];

  dm_lane_align u_align (
    .word_i   (old_word),
    .off_i    (off),
    .size_i   (req_size),
    .signed_i (req_signed),
    .wdata_i  (req_wdata),
    .rdata_o  (load_val),
    .merged_o (merged_word)
  );

  assign trace_valid = (DISPLAY_EN != 0) & store_commit;
  assign trace_pc    = req_pc;
  assign trace_addr  = {req_addr[31:2], 2'b00};
  assign trace_data  = merged_word;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = (req_we | acc_err) ? 32'd0 : load_val;
          err_d   = acc_err;
          cnt_d   = 2'(LAT - 1);
          state_d = (LAT == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Counter holds the number of edges still to wait; the last one
        // lands in RESP.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_RESP;
        end
      end
      default: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      cnt_q     <= 2'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Storage has no reset; the sweep in CLEAR zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_idx_q] <= 32'd0;
    end else if (store_commit) begin
      mem_q[word_idx] <= merged_word;
    end
  end

endmodule
